// File: rtl/io_serial_tx_pkg.sv
// Shared defines and width helpers for the io_serial_tx serial transmitter.
// Fallback defines apply when the shared IO defines header was not compiled first.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef IO_PINS
`define IO_PINS 8
`endif

package io_serial_tx_pkg;

   localparam logic LineIdle = 1'b1;
   localparam logic LineStart = 1'b0;

   // Bit counter must hold 0..WIDTH.
   function automatic int bit_cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

   // Divider counter holds 0..DIV-1, never narrower than one bit.
   function automatic int div_cnt_width(input int div);
      return (div > 1) ? $clog2(div) : 1;
   endfunction

endpackage

// File: rtl/io_serial_tx.sv
// Framed serial transmitter: one-entry holding buffer feeding a start/data/stop shifter.
// The line output is registered; a word accepted from IDLE shows its start bit two cycles later.
module io_serial_tx
   import io_serial_tx_pkg::*;
#(
   parameter int WIDTH = `DATA_WIDTH,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             port_active,
   input  logic [WIDTH-1:0] port_data,
   output logic             port_ready,
   output logic             pin_dir,
   output logic             pin_data_out,
   output logic             busy
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StStart = 2'd1;
   localparam logic [1:0] StData  = 2'd2;
   localparam logic [1:0] StStop  = 2'd3;

   localparam int BitW = bit_cnt_width(WIDTH);
   localparam int DivW = div_cnt_width(DIV);
   localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
   localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] buf_q, buf_d;
   logic             buf_full_q, buf_full_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [DivW-1:0]  div_q, div_d;
   logic [BitW-1:0]  bit_q, bit_d;
   logic             pin_q, pin_d;
   logic             live_q;
   logic             accept;
   logic             load;

   assign port_ready   = live_q & ~buf_full_q;
   assign pin_dir      = live_q;
   assign pin_data_out = pin_q;
   assign busy         = (state_q != StIdle) | buf_full_q;
   assign accept       = port_active & port_ready;

   always_comb begin
      state_d    = state_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      shift_d    = shift_q;
      div_d      = div_q;
      bit_d      = bit_q;
      load       = 1'b0;

      case (state_q)
         StIdle: begin
            if (buf_full_q) load = 1'b1;
         end
         StStart: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               bit_d   = '0;
               state_d = StData;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StData: begin
            if (div_q == DivLast) begin
               div_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == BitLast) begin
                  bit_d   = '0;
                  state_d = StStop;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         StStop: begin
            if (div_q == DivLast) begin
               div_d = '0;
               // A buffered word chains straight into the next start bit.
               if (buf_full_q) load = 1'b1;
               else state_d = StIdle;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         state_d    = StStart;
         shift_d    = buf_q;
         buf_full_d = 1'b0;
         div_d      = '0;
      end
      // Acceptance wins over the transfer so a word arriving with the load is kept.
      if (accept) begin
         buf_d      = port_data;
         buf_full_d = 1'b1;
      end

      pin_d = LineIdle;
      if (state_d == StStart) pin_d = LineStart;
      else if (state_d == StData) pin_d = shift_d[0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         shift_q    <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         pin_q      <= LineIdle;
         live_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         shift_q    <= shift_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         pin_q      <= pin_d;
         live_q     <= 1'b1;
      end
   end

endmodule
